// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// Wall-clock timekeeper (hh:mm:ss, binary) with a RUN / SET_HOUR / SET_MIN
// edit state machine. It consumes debounced one-cycle key pulses, times out
// of edit mode after TIMEOUT_S idle seconds, and drives a blink flag for the
// display mux. All outputs are registered.
module clock_set_ctrl #(
  parameter int TIMEOUT_S = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       blink_tick,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int CW = (TIMEOUT_S < 1) ? 1 : $clog2(TIMEOUT_S + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_S);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [4:0]    hour_nxt;
  logic [5:0]    minute_nxt, second_nxt;
  logic          blink_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  assign mode = state;

  // State, time fields, blink flag and timeout counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      hour   <= '0;
      minute <= '0;
      second <= '0;
      blink  <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      hour   <= hour_nxt;
      minute <= minute_nxt;
      second <= second_nxt;
      blink  <= blink_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Next-state logic: timekeeping in RUN, field edits and timeout while editing.
  always_comb begin
    state_nxt  = state;
    hour_nxt   = hour;
    minute_nxt = minute;
    second_nxt = second;
    blink_nxt  = blink;
    cnt_nxt    = cnt;

    case (state)
      RUN: begin
        blink_nxt = 1'b0;
        cnt_nxt   = '0;
        if (sec_tick) begin
          if (second == 6'd59) begin
            second_nxt = '0;
            if (minute == 6'd59) begin
              minute_nxt = '0;
              hour_nxt   = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end else begin
              minute_nxt = minute + 6'd1;
            end
          end else begin
            second_nxt = second + 6'd1;
          end
        end
        if (key_mode) begin
          state_nxt = SET_HOUR;
          blink_nxt = 1'b1;
        end
      end

      SET_HOUR, SET_MIN: begin
        if (cnt == CNT_MAX) begin
          state_nxt = RUN;
          blink_nxt = 1'b0;
          cnt_nxt   = '0;
        end else if (key_mode) begin
          cnt_nxt = '0;
          if (state == SET_HOUR) begin
            state_nxt = SET_MIN;
            blink_nxt = 1'b1;
          end else begin
            state_nxt  = RUN;
            second_nxt = '0;
            blink_nxt  = 1'b0;
          end
        end else if (key_inc) begin
          cnt_nxt   = '0;
          blink_nxt = 1'b1;
          if (state == SET_HOUR)
            hour_nxt = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
          else
            minute_nxt = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
        end else begin
          if (blink_tick)
            blink_nxt = ~blink;
          if (sec_tick && (cnt != CNT_MAX))
            cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = RUN;
        blink_nxt = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
